// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// The byte merge is per byte, so it is independent of the data width.
package mem_pkg;
  typedef enum logic [1:0] {CLEAR, INIT_DONE, RUN} state_t;

  localparam int DATA_W_DFLT = 16;
  localparam int NBYTE       = DATA_W_DFLT / 8;

  function automatic logic [7:0] be_merge(input logic [7:0] od, input logic [7:0] nw,
                                          input logic be);
    return be ? nw : od;
  endfunction
endpackage

// File: rtl/mem_clear_ctrl.sv
// Post-reset initialisation FSM: walks clr_addr over the whole array, then raises ready.
module mem_clear_ctrl import mem_pkg::*; #(
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 2**ADDR_W,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RST ? CLEAR : INIT_DONE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      // ready follows RUN by one edge, so the first RUN cycle still gates requests
      r_ready <= (r_state == RUN);
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= RUN;
        end
        INIT_DONE: r_state <= RUN;
        default:   r_state <= RUN;
      endcase
    end
  end

  assign ready    = r_ready;
  assign clr_we   = (r_state == CLEAR);
  assign clr_addr = r_cnt;
endmodule

// File: rtl/dpram_be_clr.sv
// Dual-port RAM: port A read/write with byte enables (write-first), port B read-only
// (read-first). Both read ports are registered with a one-cycle valid strobe.
module dpram_be_clr import mem_pkg::*; #(
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 2**ADDR_W,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   Din_a,
  input  logic                WE_a,
  input  logic [DATA_W/8-1:0] BE_a,
  input  logic                RE_a,
  output logic [DATA_W-1:0]   Dout_a,
  output logic                valid_a,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic                RE_b,
  output logic [DATA_W-1:0]   Dout_b,
  output logic                valid_b,
  output logic                ready
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout_a, r_dout_b;
  logic              r_valid_a, r_valid_b;

  logic              w_ready, w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [DATA_W-1:0] w_old_a, w_merge;
  logic              w_we, w_re_a, w_re_b;

  mem_clear_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RST(CLEAR_ON_RST)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_old_a = r_mem[addr_a];
  assign w_we    = w_ready & WE_a;
  assign w_re_a  = w_ready & RE_a;
  assign w_re_b  = w_ready & RE_b;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign w_merge[8*i +: 8] = be_merge(w_old_a[8*i +: 8], Din_a[8*i +: 8], BE_a[i]);
  end

  // Array has no reset; rst only suppresses same-edge writes, the FSM then zero-fills it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we)  r_mem[w_clr_addr] <= '0;
      else if (w_we) r_mem[addr_a]     <= w_merge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= w_re_a;
      r_valid_b <= w_re_b;
      if (w_re_a) r_dout_a <= w_we ? w_merge : w_old_a;
      if (w_re_b) r_dout_b <= r_mem[addr_b];
    end
  end

  assign Dout_a  = r_dout_a;
  assign Dout_b  = r_dout_b;
  assign valid_a = r_valid_a;
  assign valid_b = r_valid_b;
  assign ready   = w_ready;
endmodule

// File: tb/tb_dpram_be_clr.sv
// Self-checking bench for dpram_be_clr against a word-array model of the RAM rules.
module tb_dpram_be_clr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [15:0] Din_a = '0;
  logic        WE_a = 1'b0, RE_a = 1'b0, RE_b = 1'b0;
  logic [1:0]  BE_a = '0;
  logic [15:0] Dout_a, Dout_b;
  logic        valid_a, valid_b, ready;

  dpram_be_clr dut (
    .clk(clk), .rst(rst), .addr_a(addr_a), .Din_a(Din_a), .WE_a(WE_a), .BE_a(BE_a),
    .RE_a(RE_a), .Dout_a(Dout_a), .valid_a(valid_a), .addr_b(addr_b), .RE_b(RE_b),
    .Dout_b(Dout_b), .valid_b(valid_b), .ready(ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [15:0] m [256];
  logic [15:0] ea = '0, eb = '0;
  logic        eva = 1'b0, evb = 1'b0;
  bit          rdy = 1'b0;

  task automatic cycle(input logic we, input logic [1:0] be, input logic [15:0] din,
                       input logic [7:0] aa, input logic rea, input logic [7:0] ab,
                       input logic reb);
    logic [15:0] old_b, nw;
    @(negedge clk);
    WE_a = we; BE_a = be; Din_a = din; addr_a = aa; RE_a = rea; addr_b = ab; RE_b = reb;
    old_b = m[ab];
    if (rdy && we) begin
      nw = m[aa];
      for (int b = 0; b < 2; b++) if (be[b]) nw[8*b +: 8] = din[8*b +: 8];
      m[aa] = nw;
    end
    eva = rdy && rea;
    evb = rdy && reb;
    if (eva) ea = m[aa];
    if (evb) eb = old_b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    ea = '0; eb = '0; eva = 1'b0; evb = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 256; i++) m[i] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // edges from rst falling until ready is seen; optional gated traffic after 'from' edges
  task automatic count_fill(output int n, input bit gate, input int from);
    n = 0;
    while (n < 1000) begin
      if (gate && n >= from) begin
        WE_a = 1'b1; BE_a = 2'b11; Din_a = 16'hDEAD; addr_a = 8'h00;
        RE_a = 1'b1; RE_b = 1'b1; addr_b = 8'h00;
      end
      @(posedge clk); #1;
      n++;
      if (gate) begin
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
          errors++;
          $display("FAIL gate_valid: edge %0d got va=%b vb=%b want 0 0", n, valid_a, valid_b);
        end
      end
      if (ready === 1'b1) break;
      @(negedge clk);
    end
    rdy = 1'b1;
    WE_a = 1'b0; RE_a = 1'b0; RE_b = 1'b0; BE_a = '0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Dout_a !== 16'h0 || Dout_b !== 16'h0 || valid_a !== 1'b0 || valid_b !== 1'b0 ||
        ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %h %b %b %b want 0 0 0 0 0",
               Dout_a, Dout_b, valid_a, valid_b, ready);
    end
    apply_reset();
    count_fill(n, 1'b0, 0);
    checks++;
    if (n !== 257) begin
      errors++;
      $display("FAIL fill_latency: got %0d edges want 257", n);
    end
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 2'b00, 16'h0, 8'(i), 1'b1, 8'(255 - i), 1'b1);
      checks++;
      if (Dout_a !== 16'h0 || Dout_b !== 16'h0 || valid_a !== 1'b1 || valid_b !== 1'b1) begin
        errors++;
        $display("FAIL zero_fill: addr %0d got %h/%b %h/%b want 0000/1", i,
                 Dout_a, valid_a, Dout_b, valid_b);
      end
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 2'b11, 16'hAAAA, 8'h10, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 8'h10, 1'b1, 8'h0, 1'b0);
    checks++;
    if (Dout_a !== 16'hAAAA || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_read: got %h/%b want aaaa/1", Dout_a, valid_a);
    end
    idle();
    checks++;
    if (Dout_a !== 16'hAAAA || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got %h/%b want aaaa/0", Dout_a, valid_a);
    end
  endtask

  task automatic test_partial();
    cycle(1'b1, 2'b11, 16'h1234, 8'h20, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 2'b01, 16'hABCD, 8'h20, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 8'h20, 1'b1, 8'h20, 1'b1);
    checks++;
    if (Dout_a !== 16'h12CD || Dout_b !== 16'h12CD) begin
      errors++;
      $display("FAIL partial_be01: got %h %h want 12cd 12cd", Dout_a, Dout_b);
    end
    cycle(1'b1, 2'b00, 16'hFFFF, 8'h20, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 8'h20, 1'b1, 8'h0, 1'b0);
    checks++;
    if (Dout_a !== 16'h12CD) begin
      errors++;
      $display("FAIL partial_be00: got %h want 12cd", Dout_a);
    end
  endtask

  task automatic test_collision();
    cycle(1'b1, 2'b11, 16'h0001, 8'h30, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 2'b11, 16'h00BB, 8'h30, 1'b1, 8'h30, 1'b1);
    checks++;
    if (Dout_a !== 16'h00BB || Dout_b !== 16'h0001 || valid_a !== 1'b1 || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL collision: got a=%h b=%h want a=00bb b=0001", Dout_a, Dout_b);
    end
    cycle(1'b0, 2'b00, 16'h0, 8'h0, 1'b0, 8'h30, 1'b1);
    checks++;
    if (Dout_b !== 16'h00BB) begin
      errors++;
      $display("FAIL collision_next_b: got %h want 00bb", Dout_b);
    end
  endtask

  task automatic test_edges();
    cycle(1'b1, 2'b11, 16'hF00F, 8'hFF, 1'b0, 8'h0, 1'b0);
    cycle(1'b1, 2'b11, 16'h0FF0, 8'h00, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 8'hFF, 1'b1, 8'h00, 1'b1);
    checks++;
    if (Dout_a !== 16'hF00F || Dout_b !== 16'h0FF0) begin
      errors++;
      $display("FAIL addr_edges: got ff=%h 00=%h want f00f 0ff0", Dout_a, Dout_b);
    end
  endtask

  task automatic test_midreset_gating();
    int n;
    apply_reset();
    repeat (100) @(posedge clk);
    apply_reset();
    count_fill(n, 1'b1, 150);
    checks++;
    if (n !== 257) begin
      errors++;
      $display("FAIL midreset_latency: got %0d edges want 257", n);
    end
    cycle(1'b0, 2'b00, 16'h0, 8'h00, 1'b1, 8'h00, 1'b1);
    checks++;
    if (Dout_a !== 16'h0 || Dout_b !== 16'h0) begin
      errors++;
      $display("FAIL gate_contents: got %h %h want 0000 0000", Dout_a, Dout_b);
    end
  endtask

  task automatic test_run_reset();
    int n;
    cycle(1'b1, 2'b11, 16'hBEEF, 8'h05, 1'b0, 8'h0, 1'b0);
    cycle(1'b0, 2'b00, 16'h0, 8'h05, 1'b1, 8'h05, 1'b1);
    checks++;
    if (Dout_a !== 16'hBEEF || Dout_b !== 16'hBEEF) begin
      errors++;
      $display("FAIL run_pre: got %h %h want beef beef", Dout_a, Dout_b);
    end
    @(negedge clk);
    WE_a = 1'b1; BE_a = 2'b11; Din_a = 16'h1111; addr_a = 8'h05; RE_a = 1'b1; RE_b = 1'b1;
    apply_reset();
    WE_a = 1'b0; RE_a = 1'b0; RE_b = 1'b0;
    checks++;
    if (Dout_a !== 16'h0 || Dout_b !== 16'h0 || valid_a !== 1'b0 || valid_b !== 1'b0 ||
        ready !== 1'b0) begin
      errors++;
      $display("FAIL run_reset_out: got %h %h %b %b %b want 0 0 0 0 0",
               Dout_a, Dout_b, valid_a, valid_b, ready);
    end
    count_fill(n, 1'b0, 0);
    cycle(1'b0, 2'b00, 16'h0, 8'h05, 1'b1, 8'h05, 1'b1);
    checks++;
    if (Dout_a !== 16'h0 || Dout_b !== 16'h0) begin
      errors++;
      $display("FAIL run_reset_fill: got %h %h want 0000 0000", Dout_a, Dout_b);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom), 2'($urandom), 16'($urandom), 8'($urandom_range(0, 7)),
            1'($urandom), 8'($urandom_range(0, 7)), 1'($urandom));
      checks++;
      if (Dout_a !== ea || Dout_b !== eb || valid_a !== eva || valid_b !== evb) begin
        errors++;
        $display("FAIL random[%0d]: got %h/%b %h/%b want %h/%b %h/%b", k,
                 Dout_a, valid_a, Dout_b, valid_b, ea, eva, eb, evb);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m[i] = '0;
    test_reset();
    test_basic();
    test_partial();
    test_collision();
    test_edges();
    test_random();
    test_run_reset();
    test_midreset_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
